fir_xifu_ctrl: RTL and testbench
================================

Name: fir_xifu_ctrl

Overview:
- Per-ID instruction-lifetime tracker for the FIR XIF unit.
- Sits between the ID stage and XIF commit interface (upstream) and the EX/WB stages (downstream).
- Consumes issue events from ID, commit/kill from the core and clear from WB; produces per-ID issue/commit/kill bitmaps for EX and WB.
- Gates new issues when the offered ID slot is still in flight.

Parameters:
X_ID_WIDTH, 4 (from fir_xifu_pkg), XIF instruction ID width
X_ID_MAX, 16 (2**X_ID_WIDTH), number of tracked ID slots

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
id2ctrl_i  in  5  fir_xifu_id2ctrl_t {issue, id}: issue handshake accepted by ID this cycle
commit_valid_i  in  1  XIF commit valid
commit_id_i  in  4  XIF commit ID
commit_kill_i  in  1  XIF commit kill flag
wb2ctrl_i  in  16  fir_xifu_wb2ctrl_t: one-hot/multi-hot per-ID clear from WB (instruction retired)
issue_id_i  in  4  ID currently offered on XIF issue request (for ready computation)
issue_ready_o  out  1  slot issue_id_i available this cycle
ctrl2ex_o  out  48  fir_xifu_ctrl2ex_t {issue, commit, kill}
ctrl2wb_o  out  48  fir_xifu_ctrl2wb_t, identical content to ctrl2ex_o
outstanding_o  out  5  number of slots not FREE (0..16)
protocol_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_ni=0 at clk edge): all slots FREE; ctrl2ex_o, ctrl2wb_o = 0; outstanding_o = 0; protocol_err_o = 0. Reset mid-operation discards all slots, with no kill pulses.
- Per-slot FSM, states FREE, ISSUED, COMMITTED, KILLED. All transitions are registered (1-cycle latency).
  - FREE: id2ctrl_i.issue with id=i -> ISSUED. If commit_valid_i for i arrives the same cycle: no kill -> COMMITTED; kill -> KILLED.
  - ISSUED: commit for i, kill=0 -> COMMITTED; kill=1 -> KILLED. wb clear[i] -> ignored, err.
  - COMMITTED: clear[i] -> FREE. Kill for i -> ignored, err. Second non-kill commit -> ignored, no error.
  - KILLED: unconditionally -> FREE next cycle. Kill therefore appears as a one-cycle pulse.
- Outputs, registered from state:
  - issue[i] = state in {ISSUED, COMMITTED}
  - commit[i] = (state == COMMITTED)
  - kill[i] = (state == KILLED)
  - ctrl2wb_o == ctrl2ex_o every cycle.
- issue_ready_o (combinational) = slot[issue_id_i] FREE, or (slot COMMITTED and clear[issue_id_i]=1 this cycle), or slot KILLED.
- Simultaneous clear and issue of the same ID: clear wins first, then issue -> ISSUED. Other simultaneous events on different IDs are independent.
- Issue to a non-free slot without clear bypass: state unchanged, protocol_err_o set.
- Commit to a FREE slot (no same-cycle issue): ignored, err set.
- outstanding_o = population count of non-FREE next-state, registered. Width 5 bits holds 16 without wrap.
- protocol_err_o stays set until reset.

Test Plan:
- Reset, then issue id=3 at cycle 1 -> cycle 2: ctrl2ex_o.issue=16'h0008, commit=0, outstanding_o=1. Commit id=3 kill=0 at cycle 3 -> cycle 4: commit=16'h0008. wb clear=16'h0008 at cycle 5 -> cycle 6: all zero, outstanding_o=0.
- Issue id=5, then commit id=5 kill=1 -> kill=16'h0020 for exactly one cycle, then issue bit 5=0 and outstanding_o=0. Issue id=5 offered next cycle -> issue_ready_o=1.
- Issue and commit id=7 in the same cycle -> next cycle issue[7]=1 and commit[7]=1.
- Issue all IDs 0..15 -> outstanding_o=16. Offer issue_id_i=9 -> issue_ready_o=0. Commit 9, then assert clear[9] together with a re-issue of id 9 -> issue_ready_o=1 that cycle, next cycle slot 9 ISSUED, commit[9]=0, outstanding_o=16.
- Commit id=2 while slot 2 FREE -> no state change, protocol_err_o=1 and stays 1 until rst_ni=0.
- Assert rst_ni=0 with 4 slots in flight -> next cycle all outputs 0, no kill pulse.

Source files
------------

// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl: per-ID instruction-lifetime tracker for the FIR XIF unit.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   id2ctrl_i          {issue, id} issue handshake accepted by ID this cycle
//   commit_*_i         XIF commit valid / id / kill
//   wb2ctrl_i          per-ID retire clear from WB
//   issue_id_i         ID offered on XIF issue request
//   issue_ready_o      offered slot can accept an issue this cycle
//   ctrl2ex_o/ctrl2wb_o {issue, commit, kill} per-ID bitmaps
//   outstanding_o      number of non-free slots
//   protocol_err_o     sticky protocol-violation flag
module fir_xifu_ctrl #(
    parameter int X_ID_WIDTH = 4,
    parameter int X_ID_MAX   = 2 ** X_ID_WIDTH,
    parameter int CW         = $clog2(X_ID_MAX) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [X_ID_WIDTH:0]       id2ctrl_i,
    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,
    input  logic [X_ID_MAX-1:0]       wb2ctrl_i,
    input  logic [X_ID_WIDTH-1:0]     issue_id_i,
    output logic                      issue_ready_o,
    output logic [3*X_ID_MAX-1:0]     ctrl2ex_o,
    output logic [3*X_ID_MAX-1:0]     ctrl2wb_o,
    output logic [CW-1:0]             outstanding_o,
    output logic                      protocol_err_o
);
    typedef enum logic [1:0] {FREE, ISSUED, COMMITTED, KILLED} slot_t;

    slot_t               r_state [X_ID_MAX];
    slot_t               w_next  [X_ID_MAX];
    logic [X_ID_MAX-1:0] r_issue, r_commit, r_kill;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic                r_err;
    logic [X_ID_MAX-1:0] w_iss, w_cm, w_eff_free, w_err_vec;

    assign w_iss = {X_ID_MAX{id2ctrl_i[X_ID_WIDTH]}} & (X_ID_MAX'(1) << id2ctrl_i[X_ID_WIDTH-1:0]);
    assign w_cm  = {X_ID_MAX{commit_valid_i}} & (X_ID_MAX'(1) << commit_id_i);

    // A slot behaves as free this cycle if it is free, finishing a kill, or
    // retiring now (clear takes effect before a same-cycle issue).
    always_comb begin
        w_cnt      = '0;
        w_err_vec  = '0;
        w_eff_free = '0;
        for (int i = 0; i < X_ID_MAX; i++) begin
            w_eff_free[i] = r_state[i] == FREE || r_state[i] == KILLED ||
                            (r_state[i] == COMMITTED && wb2ctrl_i[i]);
            w_next[i] = r_state[i];
            if (w_eff_free[i]) begin
                w_next[i]    = w_iss[i] ? (w_cm[i] ? (commit_kill_i ? KILLED : COMMITTED) : ISSUED) : FREE;
                w_err_vec[i] = w_cm[i] && !w_iss[i];
            end else if (r_state[i] == ISSUED) begin
                if (w_cm[i]) w_next[i] = commit_kill_i ? KILLED : COMMITTED;
                w_err_vec[i] = w_iss[i] || wb2ctrl_i[i];
            end else begin
                w_err_vec[i] = w_iss[i] || (w_cm[i] && commit_kill_i);
            end
            w_cnt = w_cnt + CW'(w_next[i] != FREE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < X_ID_MAX; i++) r_state[i] <= FREE;
            r_issue  <= '0;
            r_commit <= '0;
            r_kill   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            for (int i = 0; i < X_ID_MAX; i++) begin
                r_state[i]  <= w_next[i];
                r_issue[i]  <= w_next[i] == ISSUED || w_next[i] == COMMITTED;
                r_commit[i] <= w_next[i] == COMMITTED;
                r_kill[i]   <= w_next[i] == KILLED;
            end
            r_cnt <= w_cnt;
            r_err <= r_err | (|w_err_vec);
        end
    end

    assign issue_ready_o  = w_eff_free[issue_id_i];
    assign ctrl2ex_o      = {r_issue, r_commit, r_kill};
    assign ctrl2wb_o      = {r_issue, r_commit, r_kill};
    assign outstanding_o  = r_cnt;
    assign protocol_err_o = r_err;
endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// tb_fir_xifu_ctrl: directed table plus randomized model comparison for fir_xifu_ctrl.
module tb_fir_xifu_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [4:0]  id2ctrl = '0;
    logic        cv = 0, ck = 0;
    logic [3:0]  cid = '0, oid = '0;
    logic [15:0] clr = '0;
    logic        rdy;
    logic [47:0] c2ex, c2wb;
    logic [4:0]  outst;
    logic        perr;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    fir_xifu_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .id2ctrl_i(id2ctrl),
        .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
        .wb2ctrl_i(clr), .issue_id_i(oid), .issue_ready_o(rdy),
        .ctrl2ex_o(c2ex), .ctrl2wb_o(c2wb), .outstanding_o(outst), .protocol_err_o(perr)
    );

    typedef struct {
        logic rn; logic iv; logic [3:0] iid; logic cv; logic [3:0] cid; logic ck;
        logic [15:0] clr; logic [3:0] oid; logic [1:0] rdy;
        logic [15:0] ei, ec, ek; logic [4:0] eo; logic ee;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic rn, logic iv, logic [3:0] iid, logic cv_, logic [3:0] cid_, logic ck_,
                                logic [15:0] clr_, logic [3:0] oid_, logic [1:0] rdy_,
                                logic [15:0] ei, logic [15:0] ec, logic [15:0] ek, logic [4:0] eo, logic ee);
        vec_t v;
        v.rn = rn; v.iv = iv; v.iid = iid; v.cv = cv_; v.cid = cid_; v.ck = ck_;
        v.clr = clr_; v.oid = oid_; v.rdy = rdy_;
        v.ei = ei; v.ec = ec; v.ek = ek; v.eo = eo; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input logic [15:0] ei, input logic [15:0] ec, input logic [15:0] ek,
                              input logic [4:0] eo, input logic ee);
        chk("issue", 64'(c2ex[47:32]), 64'(ei));
        chk("commit", 64'(c2ex[31:16]), 64'(ec));
        chk("kill", 64'(c2ex[15:0]), 64'(ek));
        chk("wb_eq_ex", 64'(c2wb), 64'(c2ex));
        chk("outstanding", 64'(outst), 64'(eo));
        chk("protocol_err", 64'(perr), 64'(ee));
    endtask

    // Reference model: each ID is either live (issued, possibly committed),
    // flagged as killed for one cycle, or free.
    bit m_live[16], m_done[16], m_killp[16];
    bit m_err;

    function automatic bit m_ready(input logic [3:0] id, input logic [15:0] c);
        return !m_live[id] || (m_done[id] && c[id]);
    endfunction

    task automatic model_step(input logic rn, input logic iv, input logic [3:0] iid, input logic cv_,
                              input logic [3:0] cid_, input logic ck_, input logic [15:0] c);
        bit nl[16], nd[16], nk[16];
        if (!rn) begin
            for (int i = 0; i < 16; i++) begin m_live[i] = 0; m_done[i] = 0; m_killp[i] = 0; end
            m_err = 0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            bit iss, cm;
            iss = iv && iid == 4'(i);
            cm  = cv_ && cid_ == 4'(i);
            nl[i] = m_live[i]; nd[i] = m_done[i]; nk[i] = 0;
            if (m_ready(4'(i), c)) begin
                nl[i] = iss && !(cm && ck_);
                nd[i] = iss && cm && !ck_;
                nk[i] = iss && cm && ck_;
                if (cm && !iss) m_err = 1;
            end else if (!m_done[i]) begin
                if (iss || c[i]) m_err = 1;
                if (cm && ck_) begin nl[i] = 0; nk[i] = 1; end
                else if (cm) nd[i] = 1;
            end else if (iss || (cm && ck_)) m_err = 1;
        end
        for (int i = 0; i < 16; i++) begin m_live[i] = nl[i]; m_done[i] = nd[i]; m_killp[i] = nk[i]; end
    endtask

    task automatic model_check;
        logic [15:0] ei, ec, ek;
        logic [4:0]  eo;
        eo = 0;
        for (int i = 0; i < 16; i++) begin
            ei[i] = m_live[i];
            ec[i] = m_live[i] && m_done[i];
            ek[i] = m_killp[i];
            eo = eo + 5'(m_live[i] || m_killp[i]);
        end
        check_outs(ei, ec, ek, eo, m_err);
    endtask

    initial begin
        logic [15:0] acc;
        // reset, issue 3, commit 3, clear 3
        tv.push_back(mk(0,0,0, 0,0,0, 16'h0,   0, 2, 16'h0,    16'h0,    16'h0,    0, 0));
        tv.push_back(mk(1,1,3, 0,0,0, 16'h0,   3, 1, 16'h0008, 16'h0,    16'h0,    1, 0));
        tv.push_back(mk(1,0,0, 1,3,0, 16'h0,   3, 0, 16'h0008, 16'h0008, 16'h0,    1, 0));
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0008,3, 1, 16'h0,    16'h0,    16'h0,    0, 0));
        // issue 5 then kill: one-cycle kill pulse, slot reusable
        tv.push_back(mk(1,1,5, 0,0,0, 16'h0,   5, 1, 16'h0020, 16'h0,    16'h0,    1, 0));
        tv.push_back(mk(1,0,0, 1,5,1, 16'h0,   5, 0, 16'h0,    16'h0,    16'h0020, 1, 0));
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0,   5, 1, 16'h0,    16'h0,    16'h0,    0, 0));
        // issue and commit 7 together, then retire
        tv.push_back(mk(1,1,7, 1,7,0, 16'h0,   7, 1, 16'h0080, 16'h0080, 16'h0,    1, 0));
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0080,7, 1, 16'h0,    16'h0,    16'h0,    0, 0));
        // fill every slot
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc[k] = 1'b1;
            tv.push_back(mk(1,1,4'(k), 0,0,0, 16'h0, 4'(k), 1, acc, 16'h0, 16'h0, 5'(k+1), 0));
        end
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0,   9, 0, 16'hFFFF, 16'h0,    16'h0,    16, 0));
        tv.push_back(mk(1,0,0, 1,9,0, 16'h0,   9, 0, 16'hFFFF, 16'h0200, 16'h0,    16, 0));
        tv.push_back(mk(1,1,9, 0,0,0, 16'h0200,9, 1, 16'hFFFF, 16'h0,    16'h0,    16, 0));
        // commit to a free slot sets the sticky error
        tv.push_back(mk(0,0,0, 0,0,0, 16'h0,   0, 2, 16'h0,    16'h0,    16'h0,    0, 0));
        tv.push_back(mk(1,0,0, 1,2,0, 16'h0,   2, 1, 16'h0,    16'h0,    16'h0,    0, 1));
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0,   2, 1, 16'h0,    16'h0,    16'h0,    0, 1));
        tv.push_back(mk(1,1,0, 0,0,0, 16'h0,   0, 1, 16'h0001, 16'h0,    16'h0,    1, 1));
        tv.push_back(mk(1,1,1, 0,0,0, 16'h0,   1, 1, 16'h0003, 16'h0,    16'h0,    2, 1));
        tv.push_back(mk(1,1,2, 1,1,1, 16'h0,   2, 1, 16'h0005, 16'h0,    16'h0002, 3, 1));
        tv.push_back(mk(1,1,3, 0,0,0, 16'h0,   3, 1, 16'h000D, 16'h0,    16'h0,    3, 1));
        tv.push_back(mk(1,1,4, 0,0,0, 16'h0,   4, 1, 16'h001D, 16'h0,    16'h0,    4, 1));
        // reset with slots in flight: everything clears, no kill pulse
        tv.push_back(mk(0,0,0, 0,0,0, 16'h0,   4, 0, 16'h0,    16'h0,    16'h0,    0, 0));
        tv.push_back(mk(1,0,0, 0,0,0, 16'h0,   4, 1, 16'h0,    16'h0,    16'h0,    0, 0));

        foreach (tv[n]) begin
            @(negedge clk);
            rst_n = tv[n].rn; id2ctrl = {tv[n].iv, tv[n].iid};
            cv = tv[n].cv; cid = tv[n].cid; ck = tv[n].ck; clr = tv[n].clr; oid = tv[n].oid;
            #1;
            if (tv[n].rdy != 2) chk($sformatf("ready[%0d]", n), 64'(rdy), 64'(tv[n].rdy[0]));
            @(posedge clk); #1;
            check_outs(tv[n].ei, tv[n].ec, tv[n].ek, tv[n].eo, tv[n].ee);
        end

        model_step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 0; id2ctrl = 0; cv = 0; clr = 0;
        @(posedge clk); #1;
        model_check();
        for (int n = 0; n < 3000; n++) begin
            logic rn, iv, c_v, c_k;
            logic [3:0] iid, c_id, o_id;
            logic [15:0] c;
            rn   = $urandom_range(0, 149) != 0;
            iv   = $urandom_range(0, 1) == 1;
            iid  = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            c_v  = $urandom_range(0, 1) == 1;
            c_id = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            c_k  = $urandom_range(0, 3) == 0;
            o_id = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            c    = ($urandom_range(0, 9) == 0) ? 16'($urandom) :
                   ($urandom_range(0, 1) == 1) ? (16'h1 << $urandom_range(0, 3)) : 16'h0;
            @(negedge clk);
            rst_n = rn; id2ctrl = {iv, iid}; cv = c_v; cid = c_id; ck = c_k; clr = c; oid = o_id;
            #1;
            chk("rand_ready", 64'(rdy), 64'(m_ready(o_id, c)));
            model_step(rn, iv, iid, c_v, c_id, c_k, c);
            @(posedge clk); #1;
            model_check();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
